systolic_feeder: RTL and testbench

Operand feeder for the output-stationary systolic PE array. It buffers one tile of operands: K columns of the left matrix (ARRAY_SIZE rows) and K rows of the right matrix (ARRAY_SIZE columns). It then streams them into the array's row (ifm) and column (w) edges with the diagonal skew the array needs. It also drives the per-diagonal `done` vector and signals tile completion.

---
 rtl/systolic_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile of operands (K columns of A, K rows of B)
// and streams them into the row/column edges of an NxN output-stationary
// systolic array with the diagonal skew the array needs, driving the
// per-diagonal done vector and a tile_done pulse.
// Optional build macro: FEEDER_PERF_EN adds perf_cycles / perf_tiles counters.
module systolic_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned DIAG_NUM   = 2*ARRAY_SIZE-1,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned K_W        = $clog2(K_MAX+1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] ld_ifm,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] ld_w,
    input  logic                             ld_last,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] ifm_out,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] w_out,
    output logic [DIAG_NUM-1:0]              done,
    output logic                             busy,
    output logic                             tile_done,
    output logic [K_W-1:0]                   k_len
`ifdef FEEDER_PERF_EN
    ,
    output logic [31:0]                      perf_cycles,
    output logic [15:0]                      perf_tiles
`endif
);

    localparam int unsigned VEC_W   = DATA_WIDTH*ARRAY_SIZE;
    localparam int unsigned SLOT_W  = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int unsigned T_W     = $clog2(K_MAX + 2*ARRAY_SIZE - 1);
    localparam int unsigned T_EXTRA = 2*ARRAY_SIZE - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FIN    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [K_W-1:0]       kcnt_q, kcnt_d;
    logic [K_W-1:0]       k_len_q, k_len_d;
    logic [T_W-1:0]       t_q, t_d;
    logic                 wr_en;

    logic [VEC_W-1:0]     ifm_out_q, ifm_out_d;
    logic [VEC_W-1:0]     w_out_q, w_out_d;
    logic [DIAG_NUM-1:0]  done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 tile_done_q, tile_done_d;
    logic                 ld_ready_q, ld_ready_d;

    // Operand storage: slot k holds beat k (A column k, B row k)
    logic [VEC_W-1:0]     ifm_mem [K_MAX];
    logic [VEC_W-1:0]     w_mem   [K_MAX];

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kcnt_q      <= '0;
            k_len_q     <= '0;
            t_q         <= '0;
            ifm_out_q   <= '0;
            w_out_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            kcnt_q      <= kcnt_d;
            k_len_q     <= k_len_d;
            t_q         <= t_d;
            ifm_out_q   <= ifm_out_d;
            w_out_q     <= w_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tile_done_q <= tile_done_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    // Buffer write on each accepted load beat; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ifm_mem[SLOT_W'(kcnt_q)] <= ld_ifm;
            w_mem[SLOT_W'(kcnt_q)]   <= ld_w;
        end
    end

    // Next-state: load counting in IDLE, stream counter in STREAM
    always_comb begin
        state_d = state_q;
        kcnt_d  = kcnt_q;
        k_len_d = k_len_q;
        t_d     = t_q;
        wr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    wr_en  = 1'b1;
                    kcnt_d = kcnt_q + K_W'(1);
                    // A full buffer ends the tile even without ld_last
                    if (ld_last || (kcnt_q == K_W'(K_MAX-1))) begin
                        k_len_d = kcnt_q + K_W'(1);
                        kcnt_d  = '0;
                        t_d     = '0;
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (32'(t_q) == 32'(k_len_q) + T_EXTRA) begin
                    t_d     = '0;
                    state_d = S_FIN;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from next state and counter
    always_comb begin
        logic [SLOT_W-1:0] slot;
        slot        = '0;
        ifm_out_d   = '0;
        w_out_d     = '0;
        done_d      = '0;
        busy_d      = (state_d != S_IDLE);
        tile_done_d = (state_d == S_FIN);
        ld_ready_d  = (state_d == S_IDLE);
        if (state_d == S_STREAM) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                if ((32'(t_d) >= i) && ((32'(t_d) - i) < 32'(k_len_d))) begin
                    slot = SLOT_W'(32'(t_d) - i);
                    // Bypass: at t=0 of a K=1 tile, slot 0 is written this same edge
                    if (wr_en && (SLOT_W'(kcnt_q) == slot)) begin
                        ifm_out_d[i*DATA_WIDTH +: DATA_WIDTH] = ld_ifm[i*DATA_WIDTH +: DATA_WIDTH];
                        w_out_d[i*DATA_WIDTH +: DATA_WIDTH]   = ld_w[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        ifm_out_d[i*DATA_WIDTH +: DATA_WIDTH] = ifm_mem[slot][i*DATA_WIDTH +: DATA_WIDTH];
                        w_out_d[i*DATA_WIDTH +: DATA_WIDTH]   = w_mem[slot][i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            for (int unsigned d = 0; d < DIAG_NUM; d++) begin
                done_d[d] = (32'(t_d) >= 32'(k_len_d) + d);
            end
        end else if (state_d == S_FIN) begin
            done_d = '1;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign ifm_out   = ifm_out_q;
    assign w_out     = w_out_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;
    assign k_len     = k_len_q;

`ifdef FEEDER_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [15:0] perf_tiles_q, perf_tiles_d;

    // Busy-cycle counter saturates; tile counter wraps
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_tiles_d  = perf_tiles_q;
        if (busy_q && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
        if (tile_done_q) begin
            perf_tiles_d = perf_tiles_q + 16'd1;
        end
    end

    // Performance counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_tiles_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_tiles_q  <= perf_tiles_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_tiles  = perf_tiles_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: directed test-plan tiles plus random tiles,
// compared against an array-based model of the skewed operand stream.
module tb_systolic_feeder;

    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int DIAG = 2*N-1;
    localparam int KMAX = 16;
    localparam int KW   = $clog2(KMAX+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [DW*N-1:0]   ld_ifm;
    logic [DW*N-1:0]   ld_w;
    logic              ld_last;
    logic [DW*N-1:0]   ifm_out;
    logic [DW*N-1:0]   w_out;
    logic [DIAG-1:0]   done;
    logic              busy;
    logic              tile_done;
    logic [KW-1:0]     k_len;
`ifdef FEEDER_PERF_EN
    logic [31:0]       perf_cycles;
    logic [15:0]       perf_tiles;
`endif

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] a_m [N][KMAX];
    logic [DW-1:0] b_m [KMAX][N];

    always #5 clk = ~clk;

    systolic_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_ifm    (ld_ifm),
        .ld_w      (ld_w),
        .ld_last   (ld_last),
        .ifm_out   (ifm_out),
        .w_out     (w_out),
        .done      (done),
        .busy      (busy),
        .tile_done (tile_done),
        .k_len     (k_len)
`ifdef FEEDER_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_tiles  (perf_tiles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Row i sees A[i][t-i] while that index lies inside the tile
    function automatic logic [DW*N-1:0] exp_ifm(input int k, input int t);
        logic [DW*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < k) v[i*DW +: DW] = a_m[i][t-i];
        return v;
    endfunction

    function automatic logic [DW*N-1:0] exp_w(input int k, input int t);
        logic [DW*N-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < k) v[j*DW +: DW] = b_m[t-j][j];
        return v;
    endfunction

    function automatic logic [DIAG-1:0] exp_done(input int k, input int t);
        logic [DIAG-1:0] v;
        v = '0;
        for (int d = 0; d < DIAG; d++)
            if (t >= k + d) v[d] = 1'b1;
        return v;
    endfunction

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
                a_m[i][kk] = DW'($urandom);
                b_m[kk][i] = DW'($urandom);
            end
    endtask

    task automatic fill_plan3;
        for (int kk = 0; kk < 3; kk++)
            for (int i = 0; i < N; i++) begin
                a_m[i][kk] = DW'(10*i + kk);
                b_m[kk][i] = DW'(10*kk + i);
            end
    endtask

    task automatic fill_plan1;
        for (int i = 0; i < N; i++) begin
            a_m[i][0] = DW'(i + 1);
            b_m[0][i] = DW'(5 + i);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_k);
        chk({tag, " ld_ready"}, 64'(ld_ready), 64'(1));
        chk({tag, " busy"}, 64'(busy), 64'(0));
        chk({tag, " tile_done"}, 64'(tile_done), 64'(0));
        chk({tag, " done"}, 64'(done), 64'(0));
        chk({tag, " ifm_out"}, 64'(ifm_out), 64'(0));
        chk({tag, " w_out"}, 64'(w_out), 64'(0));
        chk({tag, " k_len"}, 64'(k_len), 64'(exp_k));
    endtask

    // Load k beats, then stream and check every cycle; abort_t>=0 resets at that t
    task automatic run_tile(input int k, input bit use_last, input bit gaps,
                            input bit hold_valid, input int abort_t);
        for (int b = 0; b < k; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    ld_valid = 1'b0;
                    ld_ifm   = (DW*N)'($urandom);
                    ld_w     = (DW*N)'($urandom);
                    ld_last  = 1'b1;
                    step();
                    chk("gap ld_ready", 64'(ld_ready), 64'(1));
                end
            end
            ld_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                ld_ifm[i*DW +: DW] = a_m[i][b];
                ld_w[i*DW +: DW]   = b_m[b][i];
            end
            ld_last = use_last && (b == k - 1);
            chk($sformatf("beat%0d ld_ready", b), 64'(ld_ready), 64'(1));
            step();
        end
        ld_valid = hold_valid;
        ld_last  = 1'b0;
        for (int t = 0; t <= k + 2*N - 2; t++) begin
            if (t == abort_t) begin
                rst_n    = 1'b0;
                ld_valid = 1'b0;
                step();
                rst_n = 1'b1;
                check_idle("abort", 0);
                step();
                chk("abort no tile_done", 64'(tile_done), 64'(0));
                chk("abort ld_ready", 64'(ld_ready), 64'(1));
                return;
            end
            chk($sformatf("k=%0d t=%0d ifm_out", k, t), 64'(ifm_out), 64'(exp_ifm(k, t)));
            chk($sformatf("k=%0d t=%0d w_out", k, t), 64'(w_out), 64'(exp_w(k, t)));
            chk($sformatf("k=%0d t=%0d done", k, t), 64'(done), 64'(exp_done(k, t)));
            chk($sformatf("k=%0d t=%0d busy", k, t), 64'(busy), 64'(1));
            chk($sformatf("k=%0d t=%0d ld_ready", k, t), 64'(ld_ready), 64'(0));
            chk($sformatf("k=%0d t=%0d tile_done", k, t), 64'(tile_done), 64'(0));
            if (t == 0) chk($sformatf("k=%0d k_len", k), 64'(k_len), 64'(k));
            if (hold_valid) begin
                ld_ifm  = (DW*N)'($urandom);
                ld_w    = (DW*N)'($urandom);
                ld_last = 1'($urandom);
            end
            step();
        end
        chk($sformatf("k=%0d fin tile_done", k), 64'(tile_done), 64'(1));
        chk($sformatf("k=%0d fin done", k), 64'(done), 64'({DIAG{1'b1}}));
        chk($sformatf("k=%0d fin busy", k), 64'(busy), 64'(1));
        chk($sformatf("k=%0d fin ld_ready", k), 64'(ld_ready), 64'(0));
        chk($sformatf("k=%0d fin ifm_out", k), 64'(ifm_out), 64'(0));
        chk($sformatf("k=%0d fin w_out", k), 64'(w_out), 64'(0));
        step();
        check_idle($sformatf("k=%0d post", k), k);
        ld_valid = 1'b0;
    endtask

    initial begin
        int k;
        bit ul;
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_ifm   = '0;
        ld_w     = '0;
        step();
        step();
        check_idle("reset", 0);
        rst_n = 1'b1;

        fill_plan1();
        run_tile(1, 1'b1, 1'b0, 1'b0, -1);
        fill_plan3();
        run_tile(3, 1'b1, 1'b0, 1'b0, -1);
`ifdef FEEDER_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(20));
        chk("perf_tiles", 64'(perf_tiles), 64'(2));
`endif

        // Full buffer with ld_last never asserted
        fill_rand(KMAX);
        run_tile(KMAX, 1'b0, 1'b0, 1'b0, -1);

        // ld_valid held through STREAM/FIN; next tile's first beat right after FIN
        fill_rand(5);
        run_tile(5, 1'b1, 1'b0, 1'b1, -1);
        fill_rand(2);
        run_tile(2, 1'b1, 1'b0, 1'b0, -1);

        // Reset mid-stream, then a clean K=1 tile
        fill_plan3();
        run_tile(3, 1'b1, 1'b0, 1'b0, 4);
        fill_plan1();
        run_tile(1, 1'b1, 1'b0, 1'b0, -1);

        for (int n = 0; n < 20; n++) begin
            ul = 1'($urandom);
            k  = ul ? int'($urandom_range(1, KMAX)) : KMAX;
            fill_rand(k);
            run_tile(k, ul, 1'b1, 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
